// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M execute-stage multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN_DEF-1:0] DIV0_QUOT = {XLEN_DEF{1'b1}};
    localparam logic [XLEN_DEF-1:0] INT_MIN   = {1'b1, {(XLEN_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient LSB when it is non-negative.
module restoring_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN+1:0] w_sh;
    logic [XLEN+1:0] w_trial;

    assign w_sh    = {i_rem, i_quo[XLEN-1]};
    assign w_trial = w_sh - {2'b00, i_divisor};

    always_comb begin
        o_rem = w_trial[XLEN:0];
        o_quo = {i_quo[XLEN-2:0], 1'b1};
        if (w_trial[XLEN+1]) begin
            o_rem = w_sh[XLEN:0];
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/exec_muldiv.sv
// RV32M execute-stage unit: single-cycle multiplies, iterative restoring divide
// with busy/done handshake toward the hazard unit and the E->M merge mux.
module exec_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned DIV_ITERS = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            startE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] srcAE,
    input  logic [XLEN-1:0] srcBE,
    input  logic [4:0]      rdE,
    output logic            busyE,
    output logic            doneE,
    output logic [XLEN-1:0] resultE,
    output logic [4:0]      rdOutE
);

    localparam int unsigned CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

    state_t            r_state;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_negq;
    logic              r_negr;
    logic              r_isrem;
    logic [4:0]        r_rd;

    state_t            w_state_n;
    logic [XLEN:0]     w_rem_n;
    logic [XLEN-1:0]   w_quo_n;
    logic [XLEN-1:0]   w_div_n;
    logic [CNT_W-1:0]  w_cnt_n;
    logic              w_negq_n;
    logic              w_negr_n;
    logic              w_isrem_n;
    logic [4:0]        w_rd_n;
    logic              w_busy_n;
    logic              w_done_n;
    logic [XLEN-1:0]   w_result_n;
    logic [4:0]        w_rdout_n;

    // Multiply: operands extended to 2*XLEN so one unsigned product covers all signedness mixes
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_a_sgn   = (funct3E == F3_MULH) || (funct3E == F3_MULHSU);
    assign w_b_sgn   = (funct3E == F3_MULH);
    assign w_a_ext   = {{XLEN{w_a_sgn & srcAE[XLEN-1]}}, srcAE};
    assign w_b_ext   = {{XLEN{w_b_sgn & srcBE[XLEN-1]}}, srcBE};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (funct3E == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // Divide setup and early-out cases
    logic              w_is_div;
    logic              w_div_sgn;
    logic              w_is_rem;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_b_zero;
    logic              w_ovf;

    assign w_is_div  = funct3E[2];
    assign w_div_sgn = (funct3E == F3_DIV) || (funct3E == F3_REM);
    assign w_is_rem  = (funct3E == F3_REM) || (funct3E == F3_REMU);
    assign w_sa      = w_div_sgn & srcAE[XLEN-1];
    assign w_sb      = w_div_sgn & srcBE[XLEN-1];
    assign w_abs_a   = w_sa ? -srcAE : srcAE;
    assign w_abs_b   = w_sb ? -srcBE : srcBE;
    assign w_b_zero  = (srcBE == '0);
    assign w_ovf     = w_div_sgn && (srcAE == XLEN'(INT_MIN)) && (srcBE == {XLEN{1'b1}});

    logic [XLEN:0]     w_step_rem;
    logic [XLEN-1:0]   w_step_quo;
    logic [XLEN-1:0]   w_fin_q;
    logic [XLEN-1:0]   w_fin_r;

    restoring_div_step #(
        .XLEN      (XLEN)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    assign w_fin_q = r_negq ? -w_step_quo : w_step_quo;
    assign w_fin_r = r_negr ? -w_step_rem[XLEN-1:0] : w_step_rem[XLEN-1:0];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_isrem <= 1'b0;
            r_rd    <= '0;
            busyE   <= 1'b0;
            doneE   <= 1'b0;
            resultE <= '0;
            rdOutE  <= '0;
        end else begin
            r_state <= w_state_n;
            r_rem   <= w_rem_n;
            r_quo   <= w_quo_n;
            r_div   <= w_div_n;
            r_cnt   <= w_cnt_n;
            r_negq  <= w_negq_n;
            r_negr  <= w_negr_n;
            r_isrem <= w_isrem_n;
            r_rd    <= w_rd_n;
            busyE   <= w_busy_n;
            doneE   <= w_done_n;
            resultE <= w_result_n;
            rdOutE  <= w_rdout_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_n  = r_state;
        w_rem_n    = r_rem;
        w_quo_n    = r_quo;
        w_div_n    = r_div;
        w_cnt_n    = r_cnt;
        w_negq_n   = r_negq;
        w_negr_n   = r_negr;
        w_isrem_n  = r_isrem;
        w_rd_n     = r_rd;
        w_busy_n   = 1'b0;
        w_done_n   = 1'b0;
        w_result_n = resultE;
        w_rdout_n  = rdOutE;

        if (flush) begin
            w_state_n = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    w_state_n = IDLE;
                    if (startE) begin
                        if (!w_is_div || w_b_zero || w_ovf) begin
                            w_state_n = DONE;
                            w_done_n  = 1'b1;
                            w_rdout_n = rdE;
                            if (!w_is_div)
                                w_result_n = w_mul_res;
                            else if (w_b_zero)
                                w_result_n = w_is_rem ? srcAE : XLEN'(DIV0_QUOT);
                            else
                                w_result_n = w_is_rem ? '0 : XLEN'(INT_MIN);
                        end else begin
                            w_state_n = RUN;
                            w_busy_n  = 1'b1;
                            w_rem_n   = '0;
                            w_quo_n   = w_abs_a;
                            w_div_n   = w_abs_b;
                            w_cnt_n   = '0;
                            w_negq_n  = w_sa ^ w_sb;
                            w_negr_n  = w_sa;
                            w_isrem_n = w_is_rem;
                            w_rd_n    = rdE;
                        end
                    end
                end
                RUN: begin
                    w_rem_n = w_step_rem;
                    w_quo_n = w_step_quo;
                    if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
                        w_state_n  = DONE;
                        w_done_n   = 1'b1;
                        w_result_n = r_isrem ? w_fin_r : w_fin_q;
                        w_rdout_n  = r_rd;
                    end else begin
                        w_busy_n = 1'b1;
                        w_cnt_n  = r_cnt + CNT_W'(1);
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv.sv
// Self-checking bench for exec_muldiv: vector table with latency checks plus a
// result/rd scoreboard, and hand sequences for flush, held start and reset.
module tb_exec_muldiv;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        startE;
    logic [2:0]  funct3E;
    logic [31:0] srcAE;
    logic [31:0] srcBE;
    logic [4:0]  rdE;
    logic        busyE;
    logic        doneE;
    logic [31:0] resultE;
    logic [4:0]  rdOutE;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    exec_muldiv #(.XLEN(32), .DIV_ITERS(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .startE  (startE),
        .funct3E (funct3E),
        .srcAE   (srcAE),
        .srcBE   (srcBE),
        .rdE     (rdE),
        .busyE   (busyE),
        .doneE   (doneE),
        .resultE (resultE),
        .rdOutE  (rdOutE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completion pops one expected result
    always @(negedge clk) begin
        if (doneE === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_result", resultE, e.res);
                chk("sb_rd", {27'd0, rdOutE}, {27'd0, e.rd});
            end
        end
    end

    task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        tbl.push_back(v);
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        int n;
        int busy_n;
        exp_q.push_back('{res: exp, rd: rd});
        funct3E = f3; srcAE = a; srcBE = b; rdE = rd; startE = 1'b1;
        tick();
        startE = 1'b0;
        n = 1;
        busy_n = 0;
        while (doneE !== 1'b1 && n < 60) begin
            if (busyE === 1'b1) busy_n++;
            tick();
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(lat - 1));
        chk({name, "_busy_at_done"}, {31'd0, busyE}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0; flush = 1'b0; startE = 1'b0;
        funct3E = 3'd0; srcAE = '0; srcBE = '0; rdE = '0;

        add_vec("mul_neg",      3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 1);
        add_vec("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1);
        add_vec("mulhsu_max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 1);
        add_vec("mulh_m1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000, 1);
        add_vec("mul_plain",    3'b000, 32'h12345678, 32'h00000010, 5'd5,  32'h23456780, 1);
        add_vec("div_neg",      3'b100, 32'hFFFFFFEC, 32'h00000003, 5'd6,  32'hFFFFFFFA, 33);
        add_vec("rem_neg",      3'b110, 32'hFFFFFFEC, 32'h00000003, 5'd7,  32'hFFFFFFFE, 33);
        add_vec("div_negb",     3'b100, 32'h00000014, 32'hFFFFFFFD, 5'd8,  32'hFFFFFFFA, 33);
        add_vec("rem_negb",     3'b110, 32'h00000014, 32'hFFFFFFFD, 5'd9,  32'h00000002, 33);
        add_vec("divu_big",     3'b101, 32'hFFFFFFFF, 32'h00000010, 5'd10, 32'h0FFFFFFF, 33);
        add_vec("remu_big",     3'b111, 32'hFFFFFFFF, 32'h00000010, 5'd11, 32'h0000000F, 33);
        add_vec("div_min_by1",  3'b100, 32'h80000000, 32'h00000001, 5'd12, 32'h80000000, 33);
        add_vec("div_min_by2",  3'b100, 32'h80000000, 32'h00000002, 5'd13, 32'hC0000000, 33);
        add_vec("divu_by0",     3'b101, 32'h00000064, 32'h00000000, 5'd14, 32'hFFFFFFFF, 1);
        add_vec("remu_by0",     3'b111, 32'h00000064, 32'h00000000, 5'd15, 32'h00000064, 1);
        add_vec("rem_by0_neg",  3'b110, 32'hFFFFFFFB, 32'h00000000, 5'd16, 32'hFFFFFFFB, 1);
        add_vec("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1);
        add_vec("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1);

        // Reset state
        repeat (3) tick();
        chk("rst_busy", {31'd0, busyE}, 32'd0);
        chk("rst_done", {31'd0, doneE}, 32'd0);
        chk("rst_result", resultE, 32'd0);
        chk("rst_rd", {27'd0, rdOutE}, 32'd0);
        reset = 1'b1;
        tick();

        foreach (tbl[i])
            do_op(tbl[i].name, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat);

        // Flush mid-divide: no completion, outputs keep the last result
        funct3E = 3'b100; srcAE = 32'hFFFFFFEC; srcBE = 32'd3; rdE = 5'd20; startE = 1'b1;
        tick();
        startE = 1'b0;
        repeat (9) tick();
        chk("flush_busy_before", {31'd0, busyE}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_after", {31'd0, busyE}, 32'd0);
        chk("flush_done_after", {31'd0, doneE}, 32'd0);
        chk("flush_keep_result", resultE, 32'h00000000);
        chk("flush_keep_rd", {27'd0, rdOutE}, 32'd18);
        do_op("mul_after_flush", 3'b000, 32'd3, 32'd5, 5'd21, 32'd15, 1);

        // Flush wins over a simultaneous start
        flush = 1'b1; startE = 1'b1;
        funct3E = 3'b000; srcAE = 32'd9; srcBE = 32'd9; rdE = 5'd22;
        tick();
        flush = 1'b0; startE = 1'b0;
        chk("flush_start_done", {31'd0, doneE}, 32'd0);
        chk("flush_start_busy", {31'd0, busyE}, 32'd0);
        tick();
        chk("flush_start_done2", {31'd0, doneE}, 32'd0);

        // startE held high through RUN is ignored
        exp_q.push_back('{res: 32'd100, rd: 5'd23});
        funct3E = 3'b101; srcAE = 32'd1000; srcBE = 32'd10; rdE = 5'd23; startE = 1'b1;
        tick();
        funct3E = 3'b000; srcAE = 32'd2; srcBE = 32'd2; rdE = 5'd24;
        n = 1;
        while (doneE !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        startE = 1'b0;
        chk("held_start_lat", 32'(n), 32'd33);
        tick();
        chk("held_start_no_extra", {31'd0, doneE}, 32'd0);

        // Reset in the middle of a divide, then reset together with start
        funct3E = 3'b101; srcAE = 32'hFFFFFFFF; srcBE = 32'd3; rdE = 5'd25; startE = 1'b1;
        tick();
        startE = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        chk("midrst_busy", {31'd0, busyE}, 32'd0);
        chk("midrst_done", {31'd0, doneE}, 32'd0);
        chk("midrst_result", resultE, 32'd0);
        chk("midrst_rd", {27'd0, rdOutE}, 32'd0);
        funct3E = 3'b000; srcAE = 32'd6; srcBE = 32'd7; rdE = 5'd26; startE = 1'b1;
        tick();
        reset = 1'b1; startE = 1'b0;
        tick();
        chk("rst_start_done", {31'd0, doneE}, 32'd0);
        chk("rst_start_busy", {31'd0, busyE}, 32'd0);
        chk("rst_start_result", resultE, 32'd0);

        do_op("mulhu_recover", 3'b011, 32'h80000000, 32'd4, 5'd27, 32'd2, 1);
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
